// File: rtl/raiz_ctrl_if.sv
// Handshake and status bundle between the square-root sequencer and its user/datapath.
// The master drives start/maior; the slave (raiz_ctrl) drives the control word and status.
interface raiz_ctrl_if #(
  parameter int CW = 8
);
  logic          start;
  logic          maior;
  logic [8:0]    controle;
  logic [CW-1:0] ciclos;
  logic          busy;
  logic          done;

  modport master (
    output start,
    output maior,
    input  controle,
    input  ciclos,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  maior,
    output controle,
    output ciclos,
    output busy,
    output done
  );
endinterface

// File: rtl/raiz_ctrl.sv
// Moore sequencer for the integer square-root datapath (load, test, increment loop).
// Latency: 3N+4 cycles from start to done for N loop iterations; all outputs registered.
// No backpressure: start is a level sampled only in IDLE, maior only in TEST.
module raiz_ctrl #(
  parameter int CW = 8
) (
  input  logic       clock,
  input  logic       reset,
  raiz_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    TEST   = 3'd2,
    INC_D  = 3'd3,
    INC_S  = 3'd4,
    RESULT = 3'd5,
    DONE   = 3'd6
  } state_t;

  localparam logic [8:0] CW_IDLE   = 9'h000;
  localparam logic [8:0] CW_LOAD   = 9'h1E8;
  localparam logic [8:0] CW_TEST   = 9'h006;
  localparam logic [8:0] CW_INC_D  = 9'h040;
  localparam logic [8:0] CW_INC_S  = 9'h022;
  localparam logic [8:0] CW_RESULT = 9'h010;
  localparam logic [8:0] CW_DONE   = 9'h000;

  state_t        state;
  logic [8:0]    controle_q;
  logic [CW-1:0] ciclos_q;
  logic          busy_q;
  logic          done_q;

  function automatic state_t next_state(input state_t s, input logic start, input logic maior);
    case (s)
      IDLE:    next_state = start ? LOAD : IDLE;
      LOAD:    next_state = TEST;
      TEST:    next_state = maior ? RESULT : INC_D;
      INC_D:   next_state = INC_S;
      INC_S:   next_state = TEST;
      RESULT:  next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  endfunction

  function automatic logic [8:0] control_of(input state_t s);
    case (s)
      IDLE:    control_of = CW_IDLE;
      LOAD:    control_of = CW_LOAD;
      TEST:    control_of = CW_TEST;
      INC_D:   control_of = CW_INC_D;
      INC_S:   control_of = CW_INC_S;
      RESULT:  control_of = CW_RESULT;
      DONE:    control_of = CW_DONE;
      default: control_of = CW_IDLE;
    endcase
  endfunction

  // Outputs are loaded from the next state so they line up with the state register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      controle_q <= CW_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ciclos_q   <= '0;
    end else begin
      state      <= next_state(state, bus.start, bus.maior);
      controle_q <= control_of(next_state(state, bus.start, bus.maior));
      busy_q     <= (next_state(state, bus.start, bus.maior) != IDLE);
      done_q     <= (next_state(state, bus.start, bus.maior) == DONE);
      if (state == LOAD) begin
        ciclos_q <= '0;
      end else if (state == INC_S && ciclos_q != {CW{1'b1}}) begin
        ciclos_q <= ciclos_q + CW'(1);
      end
    end
  end

  assign bus.controle = controle_q;
  assign bus.ciclos   = ciclos_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_raiz_ctrl.sv
// Directed bench: an 8-bit and a 2-bit counter instance share stimulus so saturation is seen alongside normal counts.
module tb_raiz_ctrl;

  logic clock;
  logic reset;
  logic start;
  logic maior;

  int n_vec;
  int n_err;

  raiz_ctrl_if #(.CW(8)) bus8 ();
  raiz_ctrl_if #(.CW(2)) bus2 ();

  assign bus8.start = start;
  assign bus8.maior = maior;
  assign bus2.start = start;
  assign bus2.maior = maior;

  raiz_ctrl #(.CW(8)) dut8 (.clock(clock), .reset(reset), .bus(bus8.slave));
  raiz_ctrl #(.CW(2)) dut2 (.clock(clock), .reset(reset), .bus(bus2.slave));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hand-derived control word for cycle j (1 = LOAD) of an n-iteration run.
  function automatic logic [8:0] exp_cw(input int j, input int n);
    if (j == 1) return 9'h1E8;
    if (j == 3*n + 3) return 9'h010;
    if (j == 3*n + 4) return 9'h000;
    case ((j - 2) % 3)
      0:       return 9'h006;
      1:       return 9'h040;
      default: return 9'h022;
    endcase
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_idle(input string name, input int c8, input int c2);
    n_vec++;
    if (bus8.controle !== 9'h000 || bus8.busy !== 1'b0 || bus8.done !== 1'b0 ||
        bus2.controle !== 9'h000 || bus2.busy !== 1'b0 || bus2.done !== 1'b0) begin
      n_err++;
      $display("FAIL %s idle outputs: controle %h/%h busy %b/%b done %b/%b, want 000 0 0",
               name, bus8.controle, bus2.controle, bus8.busy, bus2.busy, bus8.done, bus2.done);
    end
    n_vec++;
    if (bus8.ciclos !== 8'(c8) || bus2.ciclos !== 2'(c2)) begin
      n_err++;
      $display("FAIL %s idle ciclos: got %0d/%0d want %0d/%0d", name, bus8.ciclos, bus2.ciclos, c8, c2);
    end
  endtask

  // One run of n iterations from IDLE. noise toggles maior outside TEST and start while busy;
  // hold keeps start high through DONE and checks the single IDLE cycle that follows.
  task automatic run_seq(input string name, input int n, input bit noise, input bit hold);
    int len;
    int sat;
    logic [8:0] cw;
    len = 3*n + 4;
    sat = (n > 3) ? 3 : n;
    start = 1'b1;
    maior = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    for (int j = 1; j <= len; j++) begin
      tick();
      cw = exp_cw(j, n);
      n_vec++;
      if (bus8.controle !== cw || bus2.controle !== cw) begin
        n_err++;
        $display("FAIL %s cyc%0d controle: got %h/%h want %h", name, j, bus8.controle, bus2.controle, cw);
      end
      n_vec++;
      if (bus8.busy !== 1'b1 || bus2.busy !== 1'b1 ||
          bus8.done !== (j == len) || bus2.done !== (j == len)) begin
        n_err++;
        $display("FAIL %s cyc%0d busy/done: got %b%b/%b%b want 1%b", name, j,
                 bus8.busy, bus8.done, bus2.busy, bus2.done, (j == len));
      end
      if (j == len) begin
        n_vec++;
        if (bus8.ciclos !== 8'(n) || bus2.ciclos !== 2'(sat)) begin
          n_err++;
          $display("FAIL %s ciclos at done: got %0d/%0d want %0d/%0d", name, bus8.ciclos, bus2.ciclos, n, sat);
        end
      end
      if (cw == 9'h006) maior = (((j - 2) / 3) == n);
      else maior = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (hold) start = 1'b1;
      else if (j == len) start = 1'b0;
      else start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    tick();
    check_idle({name, "_after"}, n, sat);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    maior = 1'b0;
    tick();
    tick();
    check_idle("reset_held", 0, 0);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_idle("reset_idle", 0, 0);
    end
  endtask

  task automatic test_zero_iter();
    run_seq("zero_iter", 0, 1'b0, 1'b0);
  endtask

  task automatic test_three_iter();
    run_seq("three_iter", 3, 1'b0, 1'b0);
  endtask

  task automatic test_protocol();
    for (int r = 0; r < 3; r++) run_seq("protocol", 3, 1'b1, 1'b0);
  endtask

  task automatic test_mid_reset();
    start = 1'b1;
    maior = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      tick();
      start = 1'b0;
    end
    n_vec++;
    if (bus8.controle !== 9'h040) begin
      n_err++;
      $display("FAIL mid_reset pre: controle got %h want 040", bus8.controle);
    end
    reset = 1'b0;
    tick();
    check_idle("mid_reset", 0, 0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_idle("mid_reset_quiet", 0, 0);
    end
    run_seq("post_reset", 1, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_seq("saturate", 5, 1'b0, 1'b1);
    run_seq("b2b_second", 2, 1'b0, 1'b0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    start = 1'b0;
    maior = 1'b0;
    test_reset();
    test_zero_iter();
    test_three_iter();
    test_protocol();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/raiz_ctrl.md
# raiz_ctrl

- Control unit for the integer square-root datapath. Sequences the datapath's 9-bit `controle` word through load, test and increment steps, consuming the datapath's loop-exit comparison flag.
- Counts loop iterations and signals completion with a one-cycle `done` pulse.
- Sits directly upstream of the datapath: its `controle` output drives the datapath's `controle` input bit-for-bit.

## Interface
- `CW`, default 8: width of the iteration counter `ciclos`.

- `clock`  in  1  — single clock; all state updates on the rising edge.
- `reset`  in  1  — synchronous, active-low; sampled on the rising edge of `clock`.
- `start`  in  1  — level request to begin a root computation; sampled only in IDLE.
- `maior`  in  1  — datapath status:
  - valid only while `controle` = 9'h006;
  - 1 means S > X (loop exit).
- `controle`  out  9  — datapath control word. Bit meanings:
  - [8] D mux selects constant 2; [7] S mux selects constant 4;
  - [6] D write enable; [5] S write enable; [4] R write enable; [3] X write enable;
  - [2] A mux selects ~X; [1] B mux selects S; [0] carry-in selects [2] instead of [1].
- `ciclos`  out  CW  — number of completed loop iterations for the current/last operation.
- `busy`  out  1  — high in every state except IDLE.
- `done`  out  1  — one-cycle pulse; the R register holds the result.

## Operation
- Moore FSM. `controle`, `busy` and `done` are decoded from the state register only; no input-to-output combinational path.
- States, with the control word each one drives:
  - IDLE: 9'h000. `start`=1 → LOAD, else stay.
  - LOAD: 9'h1E8 (X←data_in, D←2, S←4). Clears `ciclos` to 0. → TEST.
  - TEST: 9'h006 (ALU = ~X + S + 1). `maior`=1 → RESULT, else → INC_D.
  - INC_D: 9'h040 (D←D+2, carry-in 0). → INC_S.
  - INC_S: 9'h022 (S←S+D+1, carry-in 1). `ciclos` increments. → TEST.
  - RESULT: 9'h010 (R←ALU shifted). → DONE.
  - DONE: 9'h000, `done`=1. → IDLE.
- `maior` is ignored in every state except TEST.
- `start` is ignored in every state except IDLE. It is a level, not an edge: if `start` is held high, DONE → IDLE → LOAD runs back-to-back.
- `ciclos` arithmetic:
  - unsigned, increments by 1 per INC_S;
  - saturates at 2^CW−1 (no wrap-around);
  - holds its value through DONE and IDLE until the next LOAD.
- Reset (`reset`=0 at a clock edge), from any state including mid-loop:
  - next state is IDLE, `ciclos`=0;
  - `controle` is therefore 9'h000, `busy`=0, `done`=0;
  - reset takes priority over every transition.
- Undefined state encodings recover to IDLE on the next edge.

## Timing
- Reset values: `controle`=9'h000, `ciclos`=0, `busy`=0, `done`=0.
- `start` sampled high in IDLE at edge k gives:
  - LOAD during cycle k+1;
  - first TEST at k+2;
  - for N iterations (N TEST cycles with `maior`=0), the final TEST at k+2+3N;
  - RESULT at k+3+3N;
  - `done`=1 during cycle k+4+3N.
- Total latency from `start` to `done` is 3N+4 cycles. Minimum is 4 (N=0).
- `busy` rises in cycle k+1 and falls in the cycle after DONE.
- `ciclos` equals N during DONE.
- `maior` is sampled at the end of each TEST cycle. The datapath must settle it combinationally within that cycle.

## Test plan
- Reset, then idle:
  - hold `reset`=0 for 2 cycles, release with `start`=0;
  - required: `controle`=9'h000, `busy`=0, `done`=0, `ciclos`=0 for 5 cycles.
- Zero-iteration run:
  - pulse `start` with `maior`=1 in TEST;
  - required sequence 1E8, 006, 010, 000;
  - `done` high only in the 4th cycle after the start edge; `ciclos`=0.
- Three-iteration run:
  - `maior`=0 on the first three TESTs, 1 on the fourth;
  - required: control sequence 1E8, (006, 040, 022)×3, 006, 010, 000;
  - `done` at cycle 13; `ciclos`=3.
- Protocol checks:
  - toggle `maior` outside TEST and `start` while busy;
  - required: no change to the sequence or timing of the three-iteration run.
- Mid-loop reset:
  - assert `reset`=0 during an INC_D cycle;
  - required: next cycle `controle`=000, `busy`=0, `ciclos`=0;
  - no `done` pulse; a following `start` runs a clean sequence from LOAD.
- Saturation and back-to-back:
  - with CW=2, run 5 iterations; required: `ciclos`=3 at `done`;
  - hold `start`=1 through DONE; required: LOAD in the cycle right after the intervening IDLE.
